// File: rtl/ysyx_24090012_wbu.sv
// ysyx_24090012_wbu: write-back unit, initiator side of the register-file write port.
// Queues completed results in a small FIFO and presents them one at a time to the
// register file over rd_valid/rd_ready. Each accepted entry is held one more cycle
// in an in-flight stage that drives the commit report. The unit also exports a
// pending-destination mask that IDU uses to stall on read-after-write hazards.
//
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   in_valid/in_ready            : upstream result handshake
//   in_waddr/in_wdata/in_wen/in_next_pc : upstream result payload
//   rd_valid/rd_ready            : write request handshake to the register file
//   waddr/wdata/wen/next_pc      : head-entry payload to the register file
//   commit_valid/commit_pc       : one-cycle commit report, next PC of the entry
//   busy_mask                    : bit r set while a write to xr is queued or in flight
//   retire_count                 : number of commits since reset
module ysyx_24090012_wbu #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_WIDTH-1:0]      in_waddr,
  input  logic [DATA_WIDTH-1:0]      in_wdata,
  input  logic                       in_wen,
  input  logic [31:0]                in_next_pc,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [ADDR_WIDTH-1:0]      waddr,
  output logic [DATA_WIDTH-1:0]      wdata,
  output logic                       wen,
  output logic [31:0]                next_pc,
  output logic                       commit_valid,
  output logic [31:0]                commit_pc,
  output logic [(2**ADDR_WIDTH)-1:0] busy_mask,
  output logic [31:0]                retire_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // FIFO storage and control
  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic                  mem_wen  [DEPTH];
  logic [31:0]           mem_pc   [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;

  // In-flight stage: entry being written by the register file this cycle
  logic                  fl_valid;
  logic [ADDR_WIDTH-1:0] fl_addr;
  logic                  fl_wen;
  logic [31:0]           fl_pc;

  logic [31:0]           retire_q;
  logic                  push;
  logic                  pop;
  logic [PTR_W-1:0]      slot_off;

  // Handshakes depend only on registered count, so no rd_ready -> in_ready path
  assign in_ready = !reset && (count != CNT_W'(DEPTH));
  assign rd_valid = !reset && (count != '0);
  assign push     = in_valid && in_ready;
  assign pop      = rd_valid && rd_ready;

  // Head entry drives the write port straight from storage
  assign waddr   = mem_addr[rd_ptr];
  assign wdata   = mem_data[rd_ptr];
  assign wen     = mem_wen[rd_ptr];
  assign next_pc = mem_pc[rd_ptr];

  // Reset masks the in-flight report so a discarded entry never pulses commit
  assign commit_valid = fl_valid && !reset;
  assign commit_pc    = reset ? 32'd0 : fl_pc;
  assign retire_count = reset ? 32'd0 : retire_q;

  // Payload storage, no reset needed: validity is tracked by count
  always_ff @(posedge clock) begin
    if (push) begin
      mem_addr[wr_ptr] <= in_waddr;
      mem_data[wr_ptr] <= in_wdata;
      mem_wen[wr_ptr]  <= in_wen;
      mem_pc[wr_ptr]   <= in_next_pc;
    end
  end

  // Pointers, count, in-flight stage and retire counter
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fl_valid <= 1'b0;
      fl_addr  <= '0;
      fl_wen   <= 1'b0;
      fl_pc    <= 32'd0;
      retire_q <= 32'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        fl_addr <= mem_addr[rd_ptr];
        fl_wen  <= mem_wen[rd_ptr];
        fl_pc   <= mem_pc[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      fl_valid <= pop;
      if (fl_valid) begin
        retire_q <= retire_q + 32'd1;
      end
    end
  end

  // Pending-destination mask over valid FIFO slots plus the in-flight entry
  always_comb begin
    busy_mask = '0;
    slot_off  = '0;
    if (!reset) begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        // A slot is live when its distance from the read pointer is below count
        slot_off = PTR_W'(s) - rd_ptr;
        if ((CNT_W'(slot_off) < count) && mem_wen[PTR_W'(s)]) begin
          busy_mask[mem_addr[PTR_W'(s)]] = 1'b1;
        end
      end
      if (fl_valid && fl_wen) begin
        busy_mask[fl_addr] = 1'b1;
      end
      busy_mask[0] = 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_24090012_wbu.sv
// Self-checking bench for ysyx_24090012_wbu: per-scenario tasks with inline checks
// plus a queue-based scoreboard that tracks pushed entries and compares them against
// the write port, commit report, busy mask and retire count every cycle.
module tb_ysyx_24090012_wbu;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [31:0]   pc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          wen;
  } ent_t;

  logic            clock;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_waddr;
  logic [DW-1:0]   in_wdata;
  logic            in_wen;
  logic [31:0]     in_next_pc;
  logic            rd_valid;
  logic            rd_ready;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic            wen;
  logic [31:0]     next_pc;
  logic            commit_valid;
  logic [31:0]     commit_pc;
  logic [31:0]     busy_mask;
  logic [31:0]     retire_count;

  ysyx_24090012_wbu #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_waddr(in_waddr), .in_wdata(in_wdata), .in_wen(in_wen), .in_next_pc(in_next_pc),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .waddr(waddr), .wdata(wdata), .wen(wen), .next_pc(next_pc),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .busy_mask(busy_mask), .retire_count(retire_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_retire = 32'd0;

  // Scoreboard model state
  ent_t        mq[$];
  logic        m_fl_valid = 1'b0;
  ent_t        m_fl       = '0;
  logic [31:0] m_retire   = 32'd0;
  bit          mon_en     = 1'b0;

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    foreach (mq[i]) if (mq[i].wen) b[mq[i].addr] = 1'b1;
    if (m_fl_valid && m_fl.wen) b[m_fl.addr] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  // Scoreboard: compare mid-cycle, then advance the model by this cycle's handshakes
  always @(negedge clock) begin : scoreboard
    logic        e_bit;
    logic [31:0] e_word;
    ent_t        got;
    logic        m_pop;
    logic        m_push;
    if (mon_en) begin
      e_bit = !reset && (mq.size() != DEPTH);
      n_checks++;
      if (in_ready !== e_bit) begin
        n_fail++; $display("FAIL sb_in_ready: got %b expected %b at %0t", in_ready, e_bit, $time);
      end
      e_bit = !reset && (mq.size() != 0);
      n_checks++;
      if (rd_valid !== e_bit) begin
        n_fail++; $display("FAIL sb_rd_valid: got %b expected %b at %0t", rd_valid, e_bit, $time);
      end
      if (!reset && mq.size() != 0) begin
        got = {next_pc, waddr, wdata, wen};
        n_checks++;
        if (got !== mq[0]) begin
          n_fail++; $display("FAIL sb_payload: got %h expected %h at %0t", got, mq[0], $time);
        end
      end
      e_bit = m_fl_valid && !reset;
      n_checks++;
      if (commit_valid !== e_bit) begin
        n_fail++; $display("FAIL sb_commit_valid: got %b expected %b at %0t", commit_valid, e_bit, $time);
      end
      e_word = reset ? 32'd0 : m_fl.pc;
      n_checks++;
      if (commit_pc !== e_word) begin
        n_fail++; $display("FAIL sb_commit_pc: got %h expected %h at %0t", commit_pc, e_word, $time);
      end
      e_word = reset ? 32'd0 : model_busy();
      n_checks++;
      if (busy_mask !== e_word) begin
        n_fail++; $display("FAIL sb_busy_mask: got %h expected %h at %0t", busy_mask, e_word, $time);
      end
      e_word = reset ? 32'd0 : m_retire;
      n_checks++;
      if (retire_count !== e_word) begin
        n_fail++; $display("FAIL sb_retire_count: got %h expected %h at %0t", retire_count, e_word, $time);
      end
      if (reset) begin
        mq.delete();
        m_fl_valid = 1'b0;
        m_fl       = '0;
        m_retire   = 32'd0;
      end else begin
        m_pop  = (mq.size() != 0) && rd_ready;
        m_push = in_valid && (mq.size() != DEPTH);
        if (m_fl_valid) m_retire = m_retire + 32'd1;
        m_fl_valid = m_pop;
        if (m_pop) m_fl = mq.pop_front();
        if (m_push) mq.push_back(ent_t'({in_next_pc, in_waddr, in_wdata, in_wen}));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input ent_t e);
    in_valid   = v;
    in_waddr   = e.addr;
    in_wdata   = e.data;
    in_wen     = e.wen;
    in_next_pc = e.pc;
  endtask

  task automatic test_reset();
    reset = 1'b1; rd_ready = 1'b0; drive(1'b0, '0);
    tick();
    mon_en = 1'b1;
    tick();
    n_checks++;
    if ({rd_valid, in_ready, commit_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {rd_valid, in_ready, commit_valid});
    end
    n_checks++;
    if ({busy_mask, retire_count, commit_pc} !== 96'd0) begin
      n_fail++; $display("FAIL reset_words: got %h %h %h expected zeros", busy_mask, retire_count, commit_pc);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if ({in_ready, rd_valid, commit_valid} !== 3'b100 || retire_count !== 32'd0) begin
      n_fail++; $display("FAIL post_reset: got rdy/val/cv %b cnt %h expected 100 / 0",
                         {in_ready, rd_valid, commit_valid}, retire_count);
    end
  endtask

  task automatic test_single();
    rd_ready = 1'b1;
    drive(1'b1, '{pc: 32'h3000_0004, addr: 5'd5, data: 32'hDEAD_BEEF, wen: 1'b1});
    tick();
    drive(1'b0, '0);
    n_checks++;
    if (rd_valid !== 1'b1 || busy_mask[5] !== 1'b1) begin
      n_fail++; $display("FAIL single_p1: got rd_valid %b busy5 %b expected 1 1", rd_valid, busy_mask[5]);
    end
    tick();
    n_checks++;
    if (commit_valid !== 1'b1 || commit_pc !== 32'h3000_0004 || busy_mask[5] !== 1'b1) begin
      n_fail++; $display("FAIL single_p2: got cv %b pc %h busy5 %b expected 1 30000004 1",
                         commit_valid, commit_pc, busy_mask[5]);
    end
    tick();
    exp_retire = exp_retire + 32'd1;
    n_checks++;
    if (busy_mask[5] !== 1'b0 || commit_valid !== 1'b0 || retire_count !== exp_retire) begin
      n_fail++; $display("FAIL single_p3: got busy5 %b cv %b cnt %h expected 0 0 %h",
                         busy_mask[5], commit_valid, retire_count, exp_retire);
    end
  endtask

  task automatic test_fill_stall();
    ent_t e [3];
    int   k = 0;
    int   last = 0;
    logic hs_prev = 1'b0;
    logic hs;
    logic acc;
    e[0] = '{pc: 32'h1000_0004, addr: 5'd1, data: 32'h1111_0001, wen: 1'b1};
    e[1] = '{pc: 32'h1000_0008, addr: 5'd2, data: 32'h2222_0002, wen: 1'b1};
    e[2] = '{pc: 32'h1000_000C, addr: 5'd3, data: 32'h3333_0003, wen: 1'b1};
    rd_ready = 1'b0;
    drive(1'b1, e[0]); tick();
    drive(1'b1, e[1]); tick();
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_full: got in_ready %b expected 0", in_ready);
    end
    drive(1'b1, e[2]);
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (in_ready !== 1'b0 || {next_pc, waddr, wdata, wen} !== e[0]) begin
        n_fail++; $display("FAIL fill_stable: got rdy %b payload %h expected 0 %h",
                           in_ready, {next_pc, waddr, wdata, wen}, e[0]);
      end
    end
    // Register-file behaviour: ready drops for the cycle after each write
    for (int c = 0; c < 16; c++) begin
      rd_ready = !hs_prev;
      hs  = rd_valid && rd_ready;
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
      hs_prev = hs;
      if (commit_valid === 1'b1 && k < 3) begin
        n_checks++;
        if (commit_pc !== e[k].pc || (k > 0 && c - last != 2)) begin
          n_fail++; $display("FAIL fill_order: got pc %h gap %0d expected %h gap 2",
                             commit_pc, c - last, e[k].pc);
        end
        last = c;
        k++;
      end
    end
    rd_ready = 1'b0;
    exp_retire = exp_retire + 32'd3;
    n_checks++;
    if (k != 3 || retire_count !== exp_retire) begin
      n_fail++; $display("FAIL fill_commits: got %0d commits cnt %h expected 3 %h", k, retire_count, exp_retire);
    end
  endtask

  task automatic test_stream();
    int   i = 0;
    logic acc;
    ent_t e;
    for (int c = 0; c < 300 && i < 20; c++) begin
      e = '{pc: 32'h8000_0000 + 32'(i * 4), addr: 5'($urandom_range(1, 31)),
            data: $urandom, wen: 1'($urandom_range(0, 1))};
      drive(1'b1, e);
      rd_ready = 1'($urandom_range(0, 1));
      acc = in_ready;
      tick();
      if (acc) i++;
    end
    drive(1'b0, '0);
    rd_ready = 1'b1;
    repeat (8) tick();
    exp_retire = exp_retire + 32'd20;
    n_checks++;
    if (i != 20 || rd_valid !== 1'b0 || retire_count !== exp_retire) begin
      n_fail++; $display("FAIL stream_drain: got sent %0d rd_valid %b cnt %h expected 20 0 %h",
                         i, rd_valid, retire_count, exp_retire);
    end
  endtask

  task automatic test_x0_wen0();
    rd_ready = 1'b1;
    drive(1'b1, '{pc: 32'h4000_0004, addr: 5'd0, data: 32'h0000_1234, wen: 1'b1});
    tick();
    drive(1'b1, '{pc: 32'h4000_0008, addr: 5'd7, data: 32'h0000_0055, wen: 1'b0});
    tick();
    drive(1'b0, '0);
    for (int c = 0; c < 6; c++) begin
      n_checks++;
      if (busy_mask !== 32'd0) begin
        n_fail++; $display("FAIL x0_busy: got %h expected 0", busy_mask);
      end
      tick();
    end
    exp_retire = exp_retire + 32'd2;
    n_checks++;
    if (retire_count !== exp_retire) begin
      n_fail++; $display("FAIL x0_retire: got %h expected %h", retire_count, exp_retire);
    end
  endtask

  task automatic test_reset_mid();
    rd_ready = 1'b0;
    drive(1'b1, '{pc: 32'h5000_0004, addr: 5'd3, data: 32'hAAAA_0003, wen: 1'b1}); tick();
    drive(1'b1, '{pc: 32'h5000_0008, addr: 5'd4, data: 32'hBBBB_0004, wen: 1'b1}); tick();
    drive(1'b0, '0);
    rd_ready = 1'b1;
    tick();
    reset = 1'b1; rd_ready = 1'b0;
    #1;
    n_checks++;
    if (commit_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_commit: got %b expected 0", commit_valid);
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if ({commit_valid, rd_valid} !== 2'b00 || busy_mask !== 32'd0 || retire_count !== 32'd0) begin
        n_fail++; $display("FAIL rstmid_after: got cv/rv %b busy %h cnt %h expected 00 0 0",
                           {commit_valid, rd_valid}, busy_mask, retire_count);
      end
      tick();
    end
    exp_retire = 32'd0;
  endtask

  task automatic test_wrap();
    force dut.retire_q = 32'hFFFF_FFFF;
    m_retire = 32'hFFFF_FFFF;
    tick();
    release dut.retire_q;
    n_checks++;
    if (retire_count !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL wrap_preset: got %h expected ffffffff", retire_count);
    end
    rd_ready = 1'b1;
    drive(1'b1, '{pc: 32'h6000_0004, addr: 5'd9, data: 32'h0000_0009, wen: 1'b1});
    tick();
    drive(1'b0, '0);
    tick();
    tick();
    n_checks++;
    if (retire_count !== 32'd0) begin
      n_fail++; $display("FAIL wrap_zero: got %h expected 0", retire_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_stall();
    test_stream();
    test_x0_wen0();
    test_reset_mid();
    test_wrap();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_24090012_wbu.md
# ysyx_24090012_wbu

Write-back unit: the initiator side of the register-file write port. It accepts completed results (destination, data, write enable, next PC) from EXU/LSU into a small FIFO. It presents them one at a time to the register file over the `rd_valid`/`rd_ready` handshake and reports each commit one cycle after acceptance, aligned with the register file's internal write cycle. It also exports a pending-destination scoreboard so IDU can stall on read-after-write hazards.

## Interface
- `ADDR_WIDTH`, default 5: register address width.
- `DATA_WIDTH`, default 32: register data width.
- `DEPTH`, default 2: FIFO entries; power of two, 2 or 4.
- `clock` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: upstream result valid.
- `in_ready` out 1: FIFO can accept.
- `in_waddr` in ADDR_WIDTH: destination register.
- `in_wdata` in DATA_WIDTH: result data.
- `in_wen` in 1: result writes a register.
- `in_next_pc` in 32: PC after this instruction.
- `rd_valid` out 1: write request to register file.
- `rd_ready` in 1: register file accepts.
- `waddr` out ADDR_WIDTH: head-entry payload, driven to the register file.
- `wdata` out DATA_WIDTH: head-entry payload.
- `wen` out 1: head-entry payload.
- `next_pc` out 32: head-entry payload.
- `commit_valid` out 1: one-cycle pulse; the register file is writing this entry now.
- `commit_pc` out 32: `next_pc` of the committing entry.
- `busy_mask` out 2**ADDR_WIDTH: bit r set while a write to xr is queued or in flight.
- `retire_count` out 32: number of commits since reset.

## Operation
- FIFO
  - Circular buffer with read/write pointers plus count.
  - Push on `in_valid && in_ready`.
  - Pop on `rd_valid && rd_ready`.
  - Simultaneous push and pop: count unchanged, both pointers advance, pointers wrap modulo DEPTH.
- Upstream ready
  - `in_ready = !reset && (count != DEPTH)`.
  - Registered-count based; no combinational path from `rd_ready`.
  - A full FIFO with a pop in the same cycle still refuses the push.
- Downstream request
  - `rd_valid = (count != 0)`.
  - `waddr`/`wdata`/`wen`/`next_pc` = head entry, combinational from storage.
  - Once `rd_valid` is high, it and the payload stay stable until accepted.
  - Never deasserted without a handshake.
- In-flight stage
  - On a pop, the entry is copied into an in-flight register (`fl_valid`, addr, wen, pc).
  - `fl_valid` is high for exactly the next cycle.
  - `commit_valid = fl_valid`; `commit_pc = fl_pc`.
- Retire counter
  - `retire_count` increments by 1 in each cycle `commit_valid` is high.
  - Wraps 0xFFFF_FFFF -> 0.
- Scoreboard
  - `busy_mask[r] = 1` iff r != 0 and any valid FIFO entry or the in-flight entry has `wen=1` and `waddr=r`.
  - Bit 0 is always 0. Entries with `wen=0` contribute nothing.
  - Combinational from registered state; clears in the cycle after the commit cycle.
- Entries with `wen=0`
  - Still handshake and commit, so the PC advances.
  - `wen` is forwarded as 0.

## Timing
- Reset values (cycle after reset deasserts, and while reset is high):
  - `rd_valid=0`, `in_ready=0` during reset, `commit_valid=0`, `commit_pc=0`, `busy_mask=0`, `retire_count=0`.
  - count=0, pointers=0.
- Latency
  - Push at cycle N into an empty FIFO -> `rd_valid=1` at N+1.
  - Handshake at M -> `commit_valid` at M+1.
  - `busy_mask` bit clears at M+2.
- Throughput
  - The register file drops `rd_ready` during its write cycle, so sustained rate is one write per 2 cycles.
  - The WBU must handle `rd_ready=0` for any number of cycles.
- Back-to-back
  - A second entry may handshake at M+2 while a later push occurs at M+1.
- Reset mid-operation
  - All queued and in-flight entries are discarded.
  - No `commit_valid` pulse is produced for the discarded in-flight entry.

## Test plan
- Single write: push {x5, 0xDEADBEEF, wen=1, pc 0x3000_0004}; `rd_ready` tied 1.
  - `rd_valid` at +1.
  - `commit_valid` with `commit_pc=0x3000_0004` at +2.
  - `busy_mask[5]` high at +1..+2, low at +3.
  - `retire_count=1`.
- Fill and stall: `rd_ready=0`; push DEPTH entries (x1..x2).
  - `in_ready=0` after the DEPTH-th push; a third push is refused.
  - Payload stays stable for 10 cycles.
  - Release `rd_ready` -> commits in FIFO order, every 2 cycles.
- Full plus simultaneous pop: FIFO full, `in_valid=1`, handshake occurs.
  - Push refused that cycle, accepted the next.
  - No entry lost or duplicated; pointers wrap correctly over 20 entries.
- x0 and `wen=0`: push {x0, 0x1234, wen=1} and {x7, 0x55, wen=0}.
  - `busy_mask` stays all-zero.
  - Both commit; `retire_count` +2.
- Reset mid-flight: assert reset the cycle after a handshake with 1 entry queued.
  - No `commit_valid` pulse.
  - `rd_valid=0`, `busy_mask=0`, `retire_count=0` afterwards.
- Counter wrap: force `retire_count` to 0xFFFF_FFFF, commit one entry -> reads 0.
